// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic: Gray coding and pointer width.
package fifo_cdc_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned PTR_W_MAX       = 17;

    // Wide enough for the largest pointer; callers size-cast to their own width.
    typedef logic [PTR_W_MAX-1:0] ptr_t;

    function automatic int unsigned ptr_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int unsigned i = 1; i < PTR_W_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module ptr_sync
    import fifo_cdc_pkg::*;
#(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    localparam int unsigned N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

    (* ASYNC_REG = "TRUE" *) logic [N-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// One-side pointer/flag controller for a dual-clock FIFO (WR_MODE=1: push/full, 0: pop/empty).
// Optional fill level and almost flag are built when FIFO_PTR_LEVEL_EN is defined.
module fifo_ptr_ctrl
    import fifo_cdc_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          WR_MODE     = 1'b1,
    parameter int unsigned ALMOST_LVL  = 2**ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W:0]   rptr_gray,
    output logic              accept,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   ptr_gray,
    output logic              flag
`ifdef FIFO_PTR_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              almost_flag
`endif
);

    localparam int unsigned PW = ptr_width(ADDR_W);

    logic [PW-1:0] ptr_bin_q, ptr_bin_d;
    logic [PW-1:0] ptr_gray_q, ptr_gray_d;
    logic          flag_q, flag_d;
    logic [PW-1:0] rsync;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rptr_gray),
        .q_o   (rsync)
    );

    assign accept = req & ~flag_q;

    // Flag looks at the next pointer so it rises on the edge that registers the last slot.
    always_comb begin
        ptr_bin_d  = ptr_bin_q + {{ADDR_W{1'b0}}, accept};
        ptr_gray_d = PW'(bin2gray(ptr_t'(ptr_bin_d)));
        flag_d     = 1'b0;
        if (WR_MODE) begin
            flag_d = (ptr_gray_d == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]});
        end else begin
            flag_d = (ptr_gray_d == rsync);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
            flag_q     <= ~WR_MODE;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_gray_q <= ptr_gray_d;
            flag_q     <= flag_d;
        end
    end

    assign addr     = ptr_bin_q[ADDR_W-1:0];
    assign ptr_gray = ptr_gray_q;
    assign flag     = flag_q;

`ifdef FIFO_PTR_LEVEL_EN
    localparam logic [PW-1:0] ALMOST_V = PW'(ALMOST_LVL);

    logic [PW-1:0] rbin;
    logic [PW-1:0] level_q, level_d;
    logic          almost_q, almost_d;

    always_comb begin
        rbin     = PW'(gray2bin(ptr_t'(rsync)));
        level_d  = WR_MODE ? (ptr_bin_d - rbin) : (rbin - ptr_bin_d);
        almost_d = WR_MODE ? (level_d >= ALMOST_V) : (level_d <= ALMOST_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= '0;
            almost_q <= ~WR_MODE;
        end else begin
            level_q  <= level_d;
            almost_q <= almost_d;
        end
    end

    assign level       = level_q;
    assign almost_flag = almost_q;
`endif

endmodule
